alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand and result width.
REQ-002 Parameter NREQ, default 2, number of requesters; only 2 is supported.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_valid[i]  in  1 per requester  request present; held until accepted.
REQ-006 req_ready[i]  out  1 per requester  request accepted this cycle when high with req_valid[i].
REQ-007 req_a[i], req_b[i]  in  DATA_W each  operands.
REQ-008 req_funct7[i] in 7, req_funct3[i] in 3, req_alu_op[i] in 2  operation select, same encoding as the ALU.
REQ-009 resp_valid[i]  out  1 per requester  result available for requester i.
REQ-010 resp_ready[i]  in  1 per requester  requester consumes result.
REQ-011 resp_c[i] out DATA_W, resp_zero[i] out 1  result and zero flag.
REQ-012 alu_a, alu_b out DATA_W; alu_funct7 out 7; alu_funct3 out 3; alu_op out 2  drive the shared combinational ALU.
REQ-013 alu_c in DATA_W, alu_zero in 1  ALU result, same cycle.

Function
REQ-014 FSM states: IDLE, EXEC, RESP; reset state IDLE.
REQ-015 IDLE: if any req_valid, grant one, assert its req_ready, latch operands/op and owner ID, go to EXEC; otherwise stay.
REQ-016 EXEC (exactly 1 cycle): operand register drives ALU; capture alu_c/alu_zero into the result register; go to RESP.
REQ-017 RESP: resp_valid[owner]=1, resp_c/resp_zero stable until resp_ready[owner]=1.
REQ-018 RESP handshake with a req_valid pending: accept the new request in the same cycle and go to EXEC; without one: go to IDLE.
REQ-019 Latency: accepted at edge T, resp_valid high after edge T+2; full throughput is 1 transaction per 2 cycles.
REQ-020 Arbitration is round-robin: last_grant register; if both valid, grant the requester not in last_grant; if one valid, grant it.
REQ-021 At most one req_ready high per cycle; req_ready is 0 in EXEC and in RESP without the handshake.
REQ-022 resp_valid of the non-owner is always 0; resp_ready of the non-owner is ignored.
REQ-023 resp_c/resp_zero of the non-owner output 0.
REQ-024 alu_* outputs hold the last latched operation outside EXEC (no toggling while idle).
REQ-025 alu_op 2'b11 or an undefined funct3 is forwarded unchanged; the result is whatever the ALU returns; the arbiter does not flag it.
REQ-026 A requester deasserting req_valid before acceptance is a protocol violation; behaviour is undefined.

Reset
REQ-027 rst high: state=IDLE, last_grant=1 (requester 0 wins first tie), operand/result registers=0, all req_ready=0, all resp_valid=0.
REQ-028 rst asserted in EXEC or RESP discards the in-flight transaction; no response is ever issued for it.
REQ-029 After rst deasserts, the first grant occurs no earlier than the first rising edge.

Structure
REQ-030 Shared package alu_arb_pkg holds the FSM state encoding (IDLE/EXEC/RESP) and ALU_OP_ADDR=2'b00, ALU_OP_BRANCH=2'b01, ALU_OP_ARITH=2'b10.
REQ-031 Sub-module rr_arb2: 2-way round-robin grant from req[1:0] and last_grant, combinational one-hot grant.
REQ-032 The ALU is not instantiated inside; it is wired at the top level.

Verification
REQ-033 req0 only: ADD a=5 b=7 op=10 f3=000 f7=0, accepted at T -> resp_valid[0] after T+2, resp_c[0]=12, resp_zero[0]=0.
REQ-034 Both valid after reset: req0 SUB 9-9 (f7=0x20) granted first -> c=0, zero=1; req1 granted on the RESP handshake.
REQ-035 Both continuously valid, resp_ready tied 1, 4 transactions -> grant order 0,1,0,1; accept cycles 2 apart.
REQ-036 resp_ready[0]=0 for 5 cycles -> resp_valid[0] and resp_c[0] stay constant, all req_ready=0 throughout.
REQ-037 rst pulsed during EXEC of req1 XOR a=0xF0 b=0x0F -> resp_valid[1] never rises; next grant goes to req0 first.
REQ-038 Branch compare op=01 f3=100 a=0xFFFFFFFF b=1 -> resp_c=1; f3=110 with the same operands -> resp_c=0, zero=1.

Source files
------------

// File: rtl/alu_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package  : alu_arb_pkg
// Brief    : Shared FSM encoding and ALU operation-class codes for alu_arbiter.
// Revision : 1.0
// ============================================================================
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic [1:0] ALU_OP_ADDR   = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_ARITH  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin arbiter, combinational one-hot grant.
// Revision : 1.0
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // On a tie the requester that did not win last time goes first.
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Shares one external combinational ALU between two requesters,
//            one transaction per IDLE/RESP -> EXEC -> RESP pass.
// Revision : 1.0
// ============================================================================
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREQ   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [DATA_W-1:0] req_a      [NREQ],
    input  logic [DATA_W-1:0] req_b      [NREQ],
    input  logic [6:0]        req_funct7 [NREQ],
    input  logic [2:0]        req_funct3 [NREQ],
    input  logic [1:0]        req_alu_op [NREQ],
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [DATA_W-1:0] resp_c     [NREQ],
    output logic [NREQ-1:0]   resp_zero,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [6:0]        alu_funct7,
    output logic [2:0]        alu_funct3,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_zero
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_last_grant;
    logic              r_owner;
    logic [1:0]        w_grant;
    logic              w_grant_idx;
    logic              w_accept;
    logic              w_resp_done;

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [6:0]        r_funct7;
    logic [2:0]        r_funct3;
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_c;
    logic              r_zero;

    rr_arb2 u_rr_arb2 (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    assign w_grant_idx = w_grant[1];
    assign w_resp_done = (r_state == RESP) && resp_ready[r_owner];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                // A pending request is taken on the very edge the result is consumed.
                if (w_resp_done) begin
                    if (|req_valid) begin
                        w_accept    = 1'b1;
                        w_state_nxt = EXEC;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        req_ready = w_accept ? w_grant : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_funct7     <= '0;
            r_funct3     <= '0;
            r_op         <= '0;
            r_c          <= '0;
            r_zero       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_grant_idx;
                r_owner      <= w_grant_idx;
                r_a          <= req_a[w_grant_idx];
                r_b          <= req_b[w_grant_idx];
                r_funct7     <= req_funct7[w_grant_idx];
                r_funct3     <= req_funct3[w_grant_idx];
                r_op         <= req_alu_op[w_grant_idx];
            end
            if (r_state == EXEC) begin
                r_c    <= alu_c;
                r_zero <= alu_zero;
            end
        end
    end

    // Operand registers drive the ALU directly, so its inputs only move on a grant.
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_funct7 = r_funct7;
    assign alu_funct3 = r_funct3;
    assign alu_op     = r_op;

    for (genvar i = 0; i < NREQ; i++) begin : g_resp
        assign resp_valid[i] = (r_state == RESP) && (r_owner == 1'(i));
        assign resp_c[i]     = (r_owner == 1'(i)) ? r_c : '0;
        assign resp_zero[i]  = (r_owner == 1'(i)) ? r_zero : 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Scoreboard bench for alu_arbiter with an RV-style reference ALU.
// Revision : 1.0
// ============================================================================
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [1:0]  op;
    } txn_t;

    typedef struct {
        logic [31:0] c;
        logic        z;
        int          acc;
    } exp_t;

    typedef struct {
        int          id;
        logic [31:0] c;
        logic        z;
        int          acc;
    } done_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, resp_valid, resp_ready, resp_zero;
    logic [31:0] req_a [2];
    logic [31:0] req_b [2];
    logic [6:0]  req_funct7 [2];
    logic [2:0]  req_funct3 [2];
    logic [1:0]  req_alu_op [2];
    logic [31:0] resp_c [2];
    logic [31:0] alu_a, alu_b, alu_c;
    logic [6:0]  alu_funct7;
    logic [2:0]  alu_funct3;
    logic [1:0]  alu_op;
    logic        alu_zero;

    txn_t  rq0[$], rq1[$];
    exp_t  sb0[$], sb1[$];
    done_t done_q[$];
    int    rr_mode [2];
    logic  gap_en;
    int    n_chk = 0;
    int    n_pass = 0;

    alu_arbiter #(.DATA_W(32), .NREQ(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .req_funct7(req_funct7), .req_funct3(req_funct3), .req_alu_op(req_alu_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_c(resp_c), .resp_zero(resp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_funct7(alu_funct7),
        .alu_funct3(alu_funct3), .alu_op(alu_op),
        .alu_c(alu_c), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    // Reference ALU: RISC-V style address add, branch compare, R-type arithmetic.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [1:0] op);
        logic [31:0] r;
        r = 32'hDEAD_BEEF;
        case (op)
            ALU_OP_ADDR: r = a + b;
            ALU_OP_BRANCH: begin
                case (f3)
                    3'b000:  r = {31'd0, a == b};
                    3'b001:  r = {31'd0, a != b};
                    3'b100:  r = {31'd0, $signed(a) <  $signed(b)};
                    3'b101:  r = {31'd0, $signed(a) >= $signed(b)};
                    3'b110:  r = {31'd0, a <  b};
                    3'b111:  r = {31'd0, a >= b};
                    default: r = 32'd0;
                endcase
            end
            ALU_OP_ARITH: begin
                case (f3)
                    3'b000:  r = f7[5] ? a - b : a + b;
                    3'b001:  r = a << b[4:0];
                    3'b010:  r = {31'd0, $signed(a) < $signed(b)};
                    3'b011:  r = {31'd0, a < b};
                    3'b100:  r = a ^ b;
                    3'b101:  r = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                    3'b110:  r = a | b;
                    default: r = a & b;
                endcase
            end
            default: r = 32'hDEAD_BEEF;
        endcase
        return r;
    endfunction

    always_comb begin
        alu_c    = alu_fn(alu_a, alu_b, alu_funct7, alu_funct3, alu_op);
        alu_zero = (alu_c == 32'd0);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    endtask

    task automatic push_req(input int id, input logic [31:0] a, input logic [31:0] b,
                            input logic [6:0] f7, input logic [2:0] f3, input logic [1:0] op);
        txn_t t;
        t.a = a; t.b = b; t.f7 = f7; t.f3 = f3; t.op = op;
        if (id == 0) rq0.push_back(t);
        else         rq1.push_back(t);
    endtask

    task automatic apply(input int i, input txn_t t);
        req_a[i]      = t.a;
        req_b[i]      = t.b;
        req_funct7[i] = t.f7;
        req_funct3[i] = t.f3;
        req_alu_op[i] = t.op;
        req_valid[i]  = 1'b1;
    endtask

    // Driver: holds each request until accepted, then loads the next one.
    initial begin : driver
        logic [1:0] acc;
        logic       go;
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            req_a[i] = '0; req_b[i] = '0; req_funct7[i] = '0; req_funct3[i] = '0; req_alu_op[i] = '0;
        end
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    req_valid[i] = 1'b0;
                    go = !gap_en || ($urandom_range(0, 2) != 0);
                    if (go && i == 0 && rq0.size() > 0) apply(0, rq0.pop_front());
                    if (go && i == 1 && rq1.size() > 0) apply(1, rq1.pop_front());
                end
                case (rr_mode[i])
                    0:       resp_ready[i] = 1'b1;
                    1:       resp_ready[i] = 1'($urandom_range(0, 1));
                    default: resp_ready[i] = 1'b0;
                endcase
            end
        end
    end

    // Monitor / scoreboard state, tracked at transaction level.
    int          cyc = 0;
    int          rsp_cyc = 0;
    logic        inflight = 1'b0;
    logic        owner = 1'b0;
    logic        last = 1'b1;
    logic [31:0] m_a = '0, m_b = '0;
    logic [11:0] m_sel = '0;
    logic [1:0]  stall_prev = 2'b00;
    logic [32:0] prev_cz [2];

    initial begin : monitor
        logic       due, hs, exp_rv, id, exp_id;
        logic [1:0] acc;
        exp_t       e;
        done_t      d;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("rst_req_ready", 64'(req_ready), 64'd0);
                chk("rst_resp_valid", 64'(resp_valid), 64'd0);
                chk("rst_alu_a", 64'(alu_a), 64'd0);
                chk("rst_resp_c0", 64'(resp_c[0]), 64'd0);
                sb0.delete(); sb1.delete();
                inflight = 1'b0; owner = 1'b0; last = 1'b1;
                m_a = '0; m_b = '0; m_sel = '0; stall_prev = 2'b00;
            end else begin
                due = inflight && (cyc >= rsp_cyc);
                hs  = due && resp_ready[owner];
                chk("alu_a_hold", 64'(alu_a), 64'(m_a));
                chk("alu_b_hold", 64'(alu_b), 64'(m_b));
                chk("alu_sel_hold", 64'({alu_funct7, alu_funct3, alu_op}), 64'(m_sel));
                for (int i = 0; i < 2; i++) begin
                    exp_rv = due && (owner == 1'(i));
                    chk("resp_valid", 64'(resp_valid[i]), 64'(exp_rv));
                    if (owner != 1'(i))
                        chk("nonowner_resp", 64'({resp_c[i], resp_zero[i]}), 64'd0);
                    if (exp_rv) begin
                        if (stall_prev[i]) chk("stall_stable", 64'({resp_c[i], resp_zero[i]}), 64'(prev_cz[i]));
                        if (resp_ready[i]) begin
                            stall_prev[i] = 1'b0;
                            if ((i == 0 ? sb0.size() : sb1.size()) == 0) begin
                                chk("resp_unexpected", 64'd1, 64'd0);
                            end else begin
                                e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
                                chk("resp_c", 64'(resp_c[i]), 64'(e.c));
                                chk("resp_zero", 64'(resp_zero[i]), 64'(e.z));
                                d.id = i; d.c = resp_c[i]; d.z = resp_zero[i]; d.acc = e.acc;
                                done_q.push_back(d);
                            end
                        end else begin
                            stall_prev[i] = 1'b1;
                            prev_cz[i] = {resp_c[i], resp_zero[i]};
                        end
                    end else begin
                        stall_prev[i] = 1'b0;
                    end
                end
                acc = req_valid & req_ready;
                chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
                chk("ready_without_valid", 64'(req_ready & ~req_valid), 64'd0);
                chk("accept_when_expected", 64'(|acc), 64'((|req_valid) && (!inflight || hs)));
                if (|acc) begin
                    id     = acc[1];
                    exp_id = (req_valid == 2'b11) ? !last : req_valid[1];
                    chk("grant_id", 64'(id), 64'(exp_id));
                    e.c   = alu_fn(req_a[id], req_b[id], req_funct7[id], req_funct3[id], req_alu_op[id]);
                    e.z   = (e.c == 32'd0);
                    e.acc = cyc;
                    if (id) sb1.push_back(e);
                    else    sb0.push_back(e);
                    last = id; owner = id; inflight = 1'b1; rsp_cyc = cyc + 2;
                    m_a = req_a[id]; m_b = req_b[id];
                    m_sel = {req_funct7[id], req_funct3[id], req_alu_op[id]};
                end else if (hs) begin
                    inflight = 1'b0;
                end
            end
        end
    end

    task automatic drain(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk); #2; n++;
        end while (!(rq0.size() == 0 && rq1.size() == 0 && req_valid == 2'b00 && !inflight) && n < 3000);
        if (n >= 3000) chk({nm, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int   n;
        logic seen;
        rst = 1'b0; gap_en = 1'b0; rr_mode[0] = 0; rr_mode[1] = 0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Single ADD from requester 0.
        done_q.delete();
        push_req(0, 32'd5, 32'd7, 7'h00, 3'b000, ALU_OP_ARITH);
        drain("t_add");
        chk("t_add_count", 64'(done_q.size()), 64'd1);
        if (done_q.size() >= 1) begin
            chk("t_add_id", 64'(done_q[0].id), 64'd0);
            chk("t_add_c", 64'(done_q[0].c), 64'd12);
            chk("t_add_zero", 64'(done_q[0].z), 64'd0);
        end

        // Tie after reset: requester 0 first, requester 1 on the handshake.
        do_reset();
        done_q.delete();
        push_req(0, 32'd9, 32'd9, 7'h20, 3'b000, ALU_OP_ARITH);
        push_req(1, 32'hFF, 32'h0F, 7'h00, 3'b111, ALU_OP_ARITH);
        drain("t_tie");
        chk("t_tie_count", 64'(done_q.size()), 64'd2);
        if (done_q.size() >= 2) begin
            chk("t_tie_first_id", 64'(done_q[0].id), 64'd0);
            chk("t_tie_sub_c", 64'(done_q[0].c), 64'd0);
            chk("t_tie_sub_zero", 64'(done_q[0].z), 64'd1);
            chk("t_tie_second_id", 64'(done_q[1].id), 64'd1);
            chk("t_tie_and_c", 64'(done_q[1].c), 64'h0F);
            chk("t_tie_gap", 64'(done_q[1].acc - done_q[0].acc), 64'd2);
        end

        // Both requesters continuously valid: strict alternation, 2-cycle spacing.
        done_q.delete();
        push_req(0, 32'd1, 32'd2, 7'h00, 3'b000, ALU_OP_ADDR);
        push_req(1, 32'd10, 32'd20, 7'h00, 3'b000, ALU_OP_ADDR);
        push_req(0, 32'd3, 32'd4, 7'h00, 3'b000, ALU_OP_ADDR);
        push_req(1, 32'd30, 32'd40, 7'h00, 3'b000, ALU_OP_ADDR);
        drain("t_rr");
        chk("t_rr_count", 64'(done_q.size()), 64'd4);
        if (done_q.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("t_rr_order", 64'(done_q[k].id), 64'(k % 2));
                if (k > 0) chk("t_rr_gap", 64'(done_q[k].acc - done_q[k-1].acc), 64'd2);
            end
        end

        // Back-pressure on requester 0 while requester 1 waits.
        done_q.delete();
        rr_mode[0] = 2;
        push_req(0, 32'h100, 32'h23, 7'h00, 3'b000, ALU_OP_ADDR);
        push_req(1, 32'd7, 32'd8, 7'h00, 3'b000, ALU_OP_ADDR);
        n = 0;
        while (resp_valid[0] !== 1'b1 && n < 50) begin @(negedge clk); #2; n++; end
        chk("t_stall_resp_seen", 64'(resp_valid[0]), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #2;
            chk("t_stall_valid", 64'(resp_valid[0]), 64'd1);
            chk("t_stall_c", 64'(resp_c[0]), 64'h123);
            chk("t_stall_ready", 64'(req_ready), 64'd0);
        end
        rr_mode[0] = 0;
        drain("t_stall");
        chk("t_stall_count", 64'(done_q.size()), 64'd2);
        if (done_q.size() >= 2) chk("t_stall_req1_c", 64'(done_q[1].c), 64'd15);

        // Reset during EXEC discards the transaction; requester 0 wins afterwards.
        done_q.delete();
        push_req(1, 32'hF0, 32'h0F, 7'h00, 3'b100, ALU_OP_ARITH);
        n = 0;
        while (req_ready[1] !== 1'b1 && n < 50) begin @(negedge clk); #2; n++; end
        chk("t_rst_accept_seen", 64'(req_ready[1]), 64'd1);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(negedge clk); #2; if (resp_valid[1]) seen = 1'b1; end
        chk("t_rst_no_resp1", 64'(seen), 64'd0);
        push_req(0, 32'd2, 32'd2, 7'h00, 3'b000, ALU_OP_ADDR);
        push_req(1, 32'd3, 32'd3, 7'h00, 3'b000, ALU_OP_ADDR);
        drain("t_rst");
        chk("t_rst_count", 64'(done_q.size()), 64'd2);
        if (done_q.size() >= 1) chk("t_rst_first_id", 64'(done_q[0].id), 64'd0);

        // Signed vs unsigned branch compare.
        done_q.delete();
        push_req(0, 32'hFFFF_FFFF, 32'd1, 7'h00, 3'b100, ALU_OP_BRANCH);
        push_req(0, 32'hFFFF_FFFF, 32'd1, 7'h00, 3'b110, ALU_OP_BRANCH);
        drain("t_br");
        chk("t_br_count", 64'(done_q.size()), 64'd2);
        if (done_q.size() >= 2) begin
            chk("t_br_blt_c", 64'(done_q[0].c), 64'd1);
            chk("t_br_blt_zero", 64'(done_q[0].z), 64'd0);
            chk("t_br_bltu_c", 64'(done_q[1].c), 64'd0);
            chk("t_br_bltu_zero", 64'(done_q[1].z), 64'd1);
        end

        // Randomized traffic with random gaps and back-pressure.
        rr_mode[0] = 1; rr_mode[1] = 1; gap_en = 1'b1;
        for (int k = 0; k < 120; k++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            push_req(k % 2, a, b, ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00,
                     3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        end
        drain("t_rand");
        rr_mode[0] = 0; rr_mode[1] = 0; gap_en = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
